// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input port: register word offsets
// decoded from mem_addr[3:2].
package gpio_pkg;

    typedef logic [1:0] reg_off_t;

    localparam reg_off_t GPIO_LEVEL  = 2'd0;
    localparam reg_off_t GPIO_RISE   = 2'd1;
    localparam reg_off_t GPIO_FALL   = 2'd2;
    localparam reg_off_t GPIO_IRQ_EN = 2'd3;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input conditioner: 2-FF synchroniser, stability counter and
// debounced level flop. Emits one-cycle pulses on the edge where the
// debounced level changes.
module gpio_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             mismatch;
    logic             settle;

    // The synced pin disagrees with the debounced level; once it has done so
    // for DB_CYCLES consecutive evaluations the level follows it.
    assign mismatch = (sync_b != level_q);
    assign settle   = mismatch && (cnt == LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
        end
    end

    // Stability counter: counts mismatching cycles, restarts on agreement or settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!mismatch || settle) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Debounced level takes the synced value once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else if (settle) begin
            level_q <= sync_b;
        end
    end

    assign level      = level_q;
    assign rise_pulse = settle &  sync_b;
    assign fall_pulse = settle & ~sync_b;

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input responder: debounced pin levels, sticky
// rise/fall event registers (write-1-to-clear), interrupt enable and a
// registered level interrupt. One-cycle read latency, no wait states.
module gpio_input_port
    import gpio_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             sel,
    input  logic [31:0]      mem_addr,
    input  logic             mem_rstrb,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic [31:0]      mem_rdata,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [31:0]      rd_word;
    reg_off_t         reg_sel;
    logic             wr_en;
    logic             rd_en;
    logic             unused_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk        (clk),
            .reset      (reset),
            .pin        (gpio_in[i]),
            .level      (level[i]),
            .rise_pulse (rise_ev[i]),
            .fall_pulse (fall_ev[i])
        );
    end

    assign reg_sel     = mem_addr[3:2];
    assign wr_en       = sel & mem_wmask[0];
    assign rd_en       = sel & mem_rstrb;
    assign wdata       = mem_wdata[WIDTH-1:0];
    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wmask[3:1], mem_wdata[31:WIDTH]};

    // Write decode: W1C masks for the event registers and the selected read word.
    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        rd_word  = '0;
        if (wr_en && reg_sel == GPIO_RISE) rise_clr = wdata;
        if (wr_en && reg_sel == GPIO_FALL) fall_clr = wdata;
        case (reg_sel)
            GPIO_LEVEL:  rd_word = 32'(level);
            GPIO_RISE:   rd_word = 32'(rise);
            GPIO_FALL:   rd_word = 32'(fall);
            default:     rd_word = 32'(irq_en);
        endcase
    end

    // Sticky event bits; a new event in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_ev;
            fall <= (fall & ~fall_clr) | fall_ev;
        end
    end

    // Interrupt enable register, fully writable.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= '0;
        end else if (wr_en && reg_sel == GPIO_IRQ_EN) begin
            irq_en <= wdata;
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata <= '0;
        end else if (rd_en) begin
            mem_rdata <= rd_word;
        end
    end

    // Level interrupt from any enabled pending event.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |((rise | fall) & irq_en);
        end
    end

endmodule

// File: tb/tb_gpio_input_port.sv
// Testbench for gpio_input_port (WIDTH=5, DB_CYCLES=4): a directed vector
// table with hand-derived expectations, followed by randomized traffic
// checked against a cycle-level behavioural model.
module tb_gpio_input_port;

    localparam int WIDTH = 5;
    localparam int DB    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] gpio_in;
    logic             sel;
    logic [31:0]      mem_addr;
    logic             mem_rstrb;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wmask;
    logic [31:0]      mem_rdata;
    logic             irq;

    always #5 clk = ~clk;

    gpio_input_port #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gpio_in   (gpio_in),
        .sel       (sel),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] gpio;
        logic             sel;
        logic             rd;
        logic             wr;
        logic [1:0]       addr;
        logic [31:0]      wdata;
        logic [31:0]      exp_rdata;
        logic             exp_irq;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model state
    logic [WIDTH-1:0] m_pipe0, m_pipe1;
    logic [WIDTH-1:0] m_level, m_rise, m_fall, m_en;
    logic [31:0]      m_rdata;
    logic             m_irq;
    int               m_stable[WIDTH];

    task automatic add(input logic r, input logic [WIDTH-1:0] g, input logic s, input logic rd,
                       input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ei);
        vec_t v;
        v.rst = r; v.gpio = g; v.sel = s; v.rd = rd; v.wr = wr; v.addr = a;
        v.wdata = wd; v.exp_rdata = er; v.exp_irq = ei;
        tbl.push_back(v);
    endtask

    task automatic addn(input int n, input logic [WIDTH-1:0] g, input logic s, input logic rd,
                        input logic [1:0] a, input logic [31:0] er, input logic ei);
        for (int k = 0; k < n; k++) add(1'b0, g, s, rd, 1'b0, a, 32'd0, er, ei);
    endtask

    // Model of one clock edge. A pin's input reaches the debouncer two edges
    // after it is applied; the debounced level follows once the delayed input
    // has disagreed with it for DB consecutive edges.
    task automatic model_step(input logic r, input logic [WIDTH-1:0] g, input logic s,
                              input logic rd, input logic [3:0] wm, input logic [1:0] a,
                              input logic [31:0] wd);
        logic [WIDTH-1:0] seen, rev, fev, clr;
        logic [31:0]      rv;
        logic             nirq, we;
        if (r) begin
            m_pipe0 = '0; m_pipe1 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            m_en = '0; m_rdata = '0; m_irq = 1'b0;
            for (int i = 0; i < WIDTH; i++) m_stable[i] = 0;
            return;
        end
        seen    = m_pipe1;
        m_pipe1 = m_pipe0;
        m_pipe0 = g;
        case (a)
            2'd0:    rv = {27'd0, m_level};
            2'd1:    rv = {27'd0, m_rise};
            2'd2:    rv = {27'd0, m_fall};
            default: rv = {27'd0, m_en};
        endcase
        nirq = |((m_rise | m_fall) & m_en);
        rev = '0;
        fev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (seen[i] != m_level[i]) begin
                m_stable[i] = m_stable[i] + 1;
                if (m_stable[i] == DB) begin
                    m_level[i]  = seen[i];
                    rev[i]      = seen[i];
                    fev[i]      = ~seen[i];
                    m_stable[i] = 0;
                end
            end else begin
                m_stable[i] = 0;
            end
        end
        we  = s & wm[0];
        clr = wd[WIDTH-1:0];
        m_rise = (m_rise & ~((we && a == 2'd1) ? clr : '0)) | rev;
        m_fall = (m_fall & ~((we && a == 2'd2) ? clr : '0)) | fev;
        if (we && a == 2'd3) m_en = clr;
        if (s && rd) m_rdata = rv;
        m_irq = nirq;
    endtask

    task automatic drive(input logic r, input logic [WIDTH-1:0] g, input logic s, input logic rd,
                         input logic [3:0] wm, input logic [1:0] a, input logic [31:0] wd);
        reset     = r;
        gpio_in   = g;
        sel       = s;
        mem_rstrb = rd;
        mem_wmask = wm;
        mem_addr  = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
        mem_wdata = wd;
        @(posedge clk);
        model_step(r, g, s, rd, wm, a, wd);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] g;

        // Directed table: rst, gpio, sel, rd, wr, addr, wdata, exp_rdata, exp_irq
        add(0, 5'h00, 1, 1, 0, 2'd0, 0, 32'h00, 0);   // LEVEL after reset
        add(0, 5'h00, 1, 1, 0, 2'd1, 0, 32'h00, 0);   // RISE
        add(0, 5'h00, 1, 1, 0, 2'd2, 0, 32'h00, 0);   // FALL
        addn(6, 5'h04, 1, 1, 2'd0, 32'h00, 0);        // pin2 high, level not yet
        add(0, 5'h04, 1, 1, 0, 2'd0, 0, 32'h04, 0);   // level visible
        add(0, 5'h04, 1, 1, 0, 2'd1, 0, 32'h04, 0);   // RISE[2]
        add(0, 5'h04, 1, 1, 0, 2'd2, 0, 32'h00, 0);   // no FALL
        addn(3, 5'h05, 0, 0, 2'd0, 32'h00, 0);        // 3-cycle glitch on pin0
        addn(5, 5'h04, 0, 0, 2'd0, 32'h00, 0);
        add(0, 5'h04, 1, 1, 0, 2'd0, 0, 32'h04, 0);   // glitch ignored
        add(0, 5'h04, 1, 1, 0, 2'd1, 0, 32'h04, 0);
        add(0, 5'h04, 1, 0, 1, 2'd3, 32'h04, 32'h04, 0); // IRQ_EN=4
        add(0, 5'h04, 0, 0, 0, 2'd0, 0, 32'h04, 1);   // irq rises
        add(0, 5'h04, 1, 1, 0, 2'd3, 0, 32'h04, 1);
        add(0, 5'h04, 1, 0, 1, 2'd1, 32'h00, 32'h04, 1); // W1C of zero
        add(0, 5'h04, 1, 1, 0, 2'd1, 0, 32'h04, 1);
        add(0, 5'h04, 1, 0, 1, 2'd1, 32'h04, 32'h04, 1); // clear RISE[2]
        add(0, 5'h04, 0, 0, 0, 2'd0, 0, 32'h04, 0);   // irq drops
        add(0, 5'h04, 1, 1, 0, 2'd1, 0, 32'h00, 0);
        addn(5, 5'h06, 0, 0, 2'd0, 32'h00, 0);        // pin1 rising
        add(0, 5'h06, 1, 0, 1, 2'd1, 32'h02, 32'h00, 0); // W1C collides with event
        add(0, 5'h06, 1, 1, 0, 2'd1, 0, 32'h02, 0);   // set wins
        add(0, 5'h06, 1, 1, 0, 2'd0, 0, 32'h06, 0);
        addn(5, 5'h04, 0, 0, 2'd0, 32'h06, 0);        // pin1 falling
        add(0, 5'h04, 1, 1, 0, 2'd2, 0, 32'h00, 0);
        add(0, 5'h04, 1, 1, 0, 2'd2, 0, 32'h02, 0);
        addn(6, 5'h1F, 0, 0, 2'd0, 32'h02, 0);        // all pins high
        add(0, 5'h1F, 1, 1, 0, 2'd1, 0, 32'h1B, 0);
        add(0, 5'h1F, 1, 0, 1, 2'd3, 32'h1F, 32'h1B, 0);
        add(0, 5'h1F, 0, 0, 0, 2'd0, 0, 32'h1B, 1);
        add(1, 5'h1F, 0, 0, 0, 2'd0, 0, 32'h00, 0);   // reset with events pending
        add(0, 5'h1F, 1, 1, 0, 2'd0, 0, 32'h00, 0);
        add(0, 5'h1F, 1, 1, 0, 2'd1, 0, 32'h00, 0);
        add(0, 5'h1F, 1, 1, 0, 2'd2, 0, 32'h00, 0);
        add(0, 5'h1F, 1, 1, 0, 2'd3, 0, 32'h00, 0);
        addn(2, 5'h1F, 1, 1, 2'd0, 32'h00, 0);
        add(0, 5'h1F, 1, 1, 0, 2'd0, 0, 32'h1F, 0);   // re-debounced after reset
        add(0, 5'h1F, 1, 1, 0, 2'd1, 0, 32'h1F, 0);
        add(0, 5'h1F, 1, 0, 1, 2'd3, 32'hFFFF_FFE4, 32'h1F, 0); // upper bits ignored
        add(0, 5'h1F, 1, 1, 0, 2'd3, 0, 32'h04, 1);
        add(0, 5'h1F, 1, 0, 1, 2'd0, 32'h0000_0000, 32'h04, 1); // LEVEL read-only
        add(0, 5'h1F, 1, 1, 0, 2'd0, 0, 32'h1F, 1);
        add(0, 5'h1F, 0, 1, 0, 2'd1, 0, 32'h1F, 1);   // unselected read holds

        // Reset state
        drive(1'b1, '0, 1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        drive(1'b1, '0, 1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        check("reset rdata", mem_rdata, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].gpio, tbl[k].sel, tbl[k].rd,
                  tbl[k].wr ? 4'b0001 : 4'b0000, tbl[k].addr, tbl[k].wdata);
            check($sformatf("row%0d rdata", k), mem_rdata, tbl[k].exp_rdata);
            check($sformatf("row%0d irq", k), {31'd0, irq}, {31'd0, tbl[k].exp_irq});
        end

        // Reset in the middle of a debounce, then a fresh pattern settles
        drive(1'b0, 5'h00, 1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        drive(1'b0, 5'h00, 1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        drive(1'b0, 5'h00, 1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        drive(1'b1, 5'h0A, 1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 5'h0A, 1'b1, 1'b1, 4'h0, 2'(c % 3), 32'd0);
            check($sformatf("seq%0d rdata", c), mem_rdata, m_rdata);
            check($sformatf("seq%0d irq", c), {31'd0, irq}, {31'd0, m_irq});
        end

        // Randomized traffic against the model
        g = 5'h0A;
        for (int c = 0; c < 3000; c++) begin
            logic       r;
            logic [3:0] wm;
            r  = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) g = g ^ WIDTH'($urandom());
            wm = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
            drive(r, g, 1'($urandom()), 1'($urandom()), wm, 2'($urandom()), $urandom());
            check($sformatf("rand%0d rdata", c), mem_rdata, m_rdata);
            check($sformatf("rand%0d irq", c), {31'd0, irq}, {31'd0, m_irq});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
